// File: rtl/i2c_xfer_arbiter_pkg.sv
// Shared encodings for the I2C transfer arbiter: engine commands, FSM states, direction bit.
package i2c_xfer_arbiter_pkg;

  typedef enum logic [1:0] {
    CmdStart = 2'b00,
    CmdWrite = 2'b01,
    CmdStop  = 2'b10
  } eng_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddr,
    StData,
    StStop,
    StDone
  } arb_state_e;

  localparam logic I2cWriteBit = 1'b0;

endpackage

// File: rtl/i2c_xfer_arbiter_rr_picker.sv
// Combinational round-robin select: first set req bit at or after ptr, wrapping.
module i2c_rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         pick,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  always_comb begin
    logic          found;
    logic [IdxW-1:0] j;
    found    = 1'b0;
    pick     = '0;
    pick_idx = '0;
    j        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = IdxW'((int'(ptr) + i) % int'(NUM_REQ));
      if (!found && req[j]) begin
        found    = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = j;
      end
    end
  end

endmodule

// File: rtl/i2c_xfer_arbiter.sv
// Round-robin arbiter sequencing START/ADDR/DATA*/STOP write transfers onto a shared I2C engine.
// Optional engine watchdog with timeout port: define I2C_ARB_TIMEOUT_EN.
module i2c_xfer_arbiter
  import i2c_xfer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LEN_W   = 4
`ifdef I2C_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*7-1:0]     req_addr,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*8-1:0]     req_data,
  output logic [NUM_REQ-1:0]       req_data_rd,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic                     busy,
  output logic                     eng_cmd_valid,
  output logic [1:0]               eng_cmd,
  output logic [7:0]               eng_cmd_data,
  input  logic                     eng_cmd_ready,
  input  logic                     eng_rsp_valid,
  input  logic                     eng_rsp_nack
`ifdef I2C_ARB_TIMEOUT_EN
  ,
  output logic                     timeout
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e       state_q;
  eng_cmd_e         cmd_q;
  logic             cmd_valid_q, busy_q, err_q, err_flag_q;
  logic [7:0]       cmd_data_q;
  logic [NUM_REQ-1:0] grant_q, done_q;
  logic [IdxW-1:0]  ptr_q, owner_q;
  logic [6:0]       addr_q;
  logic [LEN_W-1:0] len_q, cnt_q;

  logic [NUM_REQ-1:0] pick;
  logic [IdxW-1:0]    pick_idx;
  logic [7:0]         data_arr [NUM_REQ];
  logic [6:0]         addr_arr [NUM_REQ];
  logic [LEN_W-1:0]   len_arr  [NUM_REQ];
  logic               active, hs, rsp;

  i2c_rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .pick    (pick),
    .pick_idx(pick_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*8 +: 8];
      addr_arr[i] = req_addr[i*7 +: 7];
      len_arr[i]  = req_len[i*LEN_W +: LEN_W];
    end
  end

  assign active = (state_q == StStart) || (state_q == StAddr) ||
                  (state_q == StData)  || (state_q == StStop);
  assign hs     = cmd_valid_q && eng_cmd_ready;
  // Responses only count in a WAIT phase, never on the handshake cycle.
  assign rsp    = active && !cmd_valid_q && eng_rsp_valid;

  assign req_data_rd   = (hs && state_q == StData) ? grant_q : '0;
  assign eng_cmd_data  = (state_q == StData) ? data_arr[owner_q] : cmd_data_q;
  assign eng_cmd       = cmd_q;
  assign eng_cmd_valid = cmd_valid_q;
  assign grant         = grant_q;
  assign done          = done_q;
  assign err           = err_q;
  assign busy          = busy_q;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
  logic [WdW-1:0] wdog_q;
  logic           timeout_q;
  assign timeout = timeout_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CmdStart;
      cmd_data_q  <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      err_flag_q  <= 1'b0;
      ptr_q       <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      if (hs) begin
        cmd_valid_q <= 1'b0;
        if (state_q == StData) cnt_q <= cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            grant_q     <= pick;
            busy_q      <= 1'b1;
            owner_q     <= pick_idx;
            addr_q      <= addr_arr[pick_idx];
            len_q       <= len_arr[pick_idx];
            cnt_q       <= '0;
            err_flag_q  <= 1'b0;
            state_q     <= StStart;
            cmd_valid_q <= 1'b1;
            cmd_q       <= CmdStart;
            cmd_data_q  <= '0;
          end
        end
        StStart: begin
          if (rsp) begin
            state_q     <= StAddr;
            cmd_valid_q <= 1'b1;
            cmd_q       <= CmdWrite;
            cmd_data_q  <= {addr_q, I2cWriteBit};
          end
        end
        StAddr: begin
          if (rsp) begin
            cmd_valid_q <= 1'b1;
            cmd_data_q  <= '0;
            if (eng_rsp_nack || len_q == '0) begin
              err_flag_q <= eng_rsp_nack;
              state_q    <= StStop;
              cmd_q      <= CmdStop;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (rsp) begin
            cmd_valid_q <= 1'b1;
            if (eng_rsp_nack || cnt_q == len_q) begin
              err_flag_q <= eng_rsp_nack;
              state_q    <= StStop;
              cmd_q      <= CmdStop;
            end
          end
        end
        StStop: begin
          if (rsp) begin
            state_q <= StDone;
            done_q  <= grant_q;
            err_q   <= err_flag_q;
            cmd_q   <= CmdStart;
          end
        end
        StDone: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
        default: state_q <= StIdle;
      endcase
`ifdef I2C_ARB_TIMEOUT_EN
      // Every phase entry coincides with a handshake or a response, so those restart the count.
      if (active) begin
        if (hs || rsp) begin
          wdog_q <= '0;
        end else if (wdog_q == WdW'(TIMEOUT_CYC - 1)) begin
          state_q     <= StDone;
          cmd_valid_q <= 1'b0;
          cmd_q       <= CmdStart;
          cmd_data_q  <= '0;
          done_q      <= grant_q;
          err_q       <= 1'b1;
          timeout_q   <= 1'b1;
          wdog_q      <= '0;
        end else begin
          wdog_q <= wdog_q + 1'b1;
        end
      end else begin
        wdog_q <= '0;
      end
`endif
    end
  end

endmodule
